// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The master view belongs to the controller and the slave view to the datapath.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;

    logic       pcWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [3:0] aluCtr;
    logic [3:0] state;
    logic       illegal;
    logic       memTimeout;

    modport master (
        input  opcode, funct, zero, memReady,
        output pcWrite, iorD, memRead, memWrite, irWrite, memToReg, regDst,
               regWrite, aluSrcA, aluSrcB, pcSource, aluCtr, state,
               illegal, memTimeout
    );

    modport slave (
        output opcode, funct, zero, memReady,
        input  pcWrite, iorD, memRead, memWrite, irWrite, memToReg, regDst,
               regWrite, aluSrcA, aluSrcB, pcSource, aluCtr, state,
               illegal, memTimeout
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback with memory wait timeout.
// Optional macro IMM_ALU_EN adds addi/andi/ori/slti through states I_EXEC(10) and I_WB(11).
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mips_multicycle_ctrl_if.master       bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef IMM_ALU_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
`endif

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // The counter holds completed wait cycles; it never needs to exceed MEM_TIMEOUT-1.
    localparam int            CW         = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic          TIMEOUT_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
`ifdef IMM_ALU_EN
        ,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
`endif
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
    logic          illegal_reg, timeout_reg;
    logic          set_illegal;
    logic          wait_state;
    logic          timeout_hit;

    logic [3:0]    r_alu_ctr;
    logic          r_known;
`ifdef IMM_ALU_EN
    logic [3:0]    i_alu_ctr;
`endif

    logic          pc_write, ior_d, mem_read, mem_write, ir_write;
    logic          mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, pc_source;
    logic [3:0]    alu_ctr;

    always_comb begin
        r_alu_ctr = ALU_ADD;
        r_known   = 1'b1;
        case (bus.funct)
            6'b100000: r_alu_ctr = ALU_ADD;
            6'b100010: r_alu_ctr = ALU_SUB;
            6'b100100: r_alu_ctr = ALU_AND;
            6'b100101: r_alu_ctr = ALU_OR;
            6'b101010: r_alu_ctr = ALU_SLT;
            default:   r_known   = 1'b0;
        endcase
    end

`ifdef IMM_ALU_EN
    always_comb begin
        i_alu_ctr = ALU_ADD;
        case (bus.opcode)
            OP_ANDI: i_alu_ctr = ALU_AND;
            OP_ORI:  i_alu_ctr = ALU_OR;
            OP_SLTI: i_alu_ctr = ALU_SLT;
            default: i_alu_ctr = ALU_ADD;
        endcase
    end
`endif

    // A timeout fires on the MEM_TIMEOUT-th consecutive not-ready cycle of a wait state.
    assign wait_state  = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                         (state_reg == S_MEM_WR);
    assign timeout_hit = TIMEOUT_EN && wait_state && !bus.memReady &&
                         (wait_cnt_reg == WAIT_LIMIT);

    always_comb begin
        state_next  = state_reg;
        set_illegal = 1'b0;
        pc_write    = 1'b0;
        ior_d       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_source   = 2'b00;
        alu_ctr     = ALU_ADD;

        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.memReady;
                pc_write  = bus.memReady;
                if (bus.memReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_RTYPE:     state_next = S_R_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
`ifdef IMM_ALU_EN
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_I_EXEC;
`endif
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                if (bus.memReady)  state_next = S_MEM_WB;
                else if (timeout_hit) state_next = S_FETCH;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
                if (bus.memReady || timeout_hit) state_next = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctr   = r_alu_ctr;
                if (r_known) begin
                    state_next = S_R_WB;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = S_FETCH;
                end
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                alu_ctr    = r_alu_ctr;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctr    = ALU_SUB;
                pc_source  = 2'b01;
                pc_write   = bus.zero;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                state_next = S_FETCH;
            end
`ifdef IMM_ALU_EN
            S_I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_ctr    = i_alu_ctr;
                state_next = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
`endif
            default: state_next = S_FETCH;
        endcase

        // Keep the datapath quiet while reset is held, whatever the state decode says.
        if (!rst_n) begin
            pc_write   = 1'b0;
            ior_d      = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            mem_to_reg = 1'b0;
            reg_dst    = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_source  = 2'b00;
            alu_ctr    = ALU_ADD;
        end
    end

    always_comb begin
        if (timeout_hit || bus.memReady || !wait_state || (state_next != state_reg))
            wait_cnt_next = '0;
        else
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            illegal_reg  <= illegal_reg | set_illegal;
            timeout_reg  <= timeout_reg | timeout_hit;
        end
    end

    assign bus.pcWrite    = pc_write;
    assign bus.iorD       = ior_d;
    assign bus.memRead    = mem_read;
    assign bus.memWrite   = mem_write;
    assign bus.irWrite    = ir_write;
    assign bus.memToReg   = mem_to_reg;
    assign bus.regDst     = reg_dst;
    assign bus.regWrite   = reg_write;
    assign bus.aluSrcA    = alu_src_a;
    assign bus.aluSrcB    = alu_src_b;
    assign bus.pcSource   = pc_source;
    assign bus.aluCtr     = alu_ctr;
    assign bus.state      = state_reg;
    assign bus.illegal    = illegal_reg;
    assign bus.memTimeout = timeout_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected state, strobes and flags.
// A second instance with MEM_TIMEOUT=2 covers the abandoned-access paths.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] op_drv;
    logic [5:0] fn_drv;
    logic       mr_drv;
    logic       z_drv;

    int checks = 0;
    int passed = 0;
    logic exp_ill = 1'b0;
    logic exp_to  = 1'b0;

    mips_multicycle_ctrl_if bus();
    mips_multicycle_ctrl_if bus_to();

    assign bus.opcode      = op_drv;
    assign bus.funct       = fn_drv;
    assign bus.memReady    = mr_drv;
    assign bus.zero        = z_drv;
    assign bus_to.opcode   = op_drv;
    assign bus_to.funct    = fn_drv;
    assign bus_to.memReady = mr_drv;
    assign bus_to.zero     = z_drv;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(255)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
    mips_multicycle_ctrl #(.MEM_TIMEOUT(2))   dut_to (.clk(clk), .rst_n(rst_n), .bus(bus_to));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {pcWrite,iorD,memRead,memWrite,irWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,pcSource,aluCtr}
    logic [16:0] obs_main, obs_to;
    assign obs_main = {bus.pcWrite, bus.iorD, bus.memRead, bus.memWrite, bus.irWrite,
                       bus.memToReg, bus.regDst, bus.regWrite, bus.aluSrcA,
                       bus.aluSrcB, bus.pcSource, bus.aluCtr};
    assign obs_to   = {bus_to.pcWrite, bus_to.iorD, bus_to.memRead, bus_to.memWrite,
                       bus_to.irWrite, bus_to.memToReg, bus_to.regDst, bus_to.regWrite,
                       bus_to.aluSrcA, bus_to.aluSrcB, bus_to.pcSource, bus_to.aluCtr};

    function automatic logic [16:0] mk(input logic pcw, iord, mr, mw, irw, m2r, rd, rw, sa,
                                       input logic [1:0] sb, ps, input logic [3:0] ac);
        return {pcw, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, ac};
    endfunction

    function automatic logic [16:0] o_rst();            return mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'b0010); endfunction
    function automatic logic [16:0] o_fetch(input logic r); return mk(r,0,1,0,r,0,0,0,0,2'b01,2'b00,4'b0010); endfunction
    function automatic logic [16:0] o_dec();            return mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0010); endfunction
    function automatic logic [16:0] o_maddr();          return mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010); endfunction
    function automatic logic [16:0] o_mrd();            return mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,4'b0010); endfunction
    function automatic logic [16:0] o_mwb();            return mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,4'b0010); endfunction
    function automatic logic [16:0] o_mwr();            return mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,4'b0010); endfunction
    function automatic logic [16:0] o_rexec(input logic [3:0] ac); return mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,ac); endfunction
    function automatic logic [16:0] o_rwb(input logic [3:0] ac);   return mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,ac); endfunction
    function automatic logic [16:0] o_br(input logic z);  return mk(z,0,0,0,0,0,0,0,1,2'b00,2'b01,4'b0110); endfunction
    function automatic logic [16:0] o_jmp();            return mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,4'b0010); endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic        z;
        logic [3:0]  st;
        logic [16:0] outs;
        logic [1:0]  flg;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                        input logic z, input logic [3:0] st, input logic [16:0] outs,
                        input string tag);
        exp_t e;
        e.op = op; e.fn = fn; e.mr = mr; e.z = z; e.st = st; e.outs = outs;
        e.flg = {exp_ill, exp_to}; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd0 || obs_main !== o_rst()) $display("FAIL reset_hold state=%0d outs=%h want 0/%h", bus.state, obs_main, o_rst());
        else passed++;
        checks++;
        if ({bus.illegal, bus.memTimeout, bus_to.illegal, bus_to.memTimeout} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {bus.illegal, bus.memTimeout, bus_to.illegal, bus_to.memTimeout});
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(6'b100011, 6'd0, 1, 0, 4'd0, o_fetch(1), "rst.fetch");
        push(6'b100011, 6'd0, 1, 0, 4'd1, o_dec(),    "rst.decode");
        push(6'b100011, 6'd0, 1, 0, 4'd2, o_maddr(),  "rst.maddr");
        push(6'b100011, 6'd0, 0, 0, 4'd3, o_mrd(),    "rst.memrd");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op_drv = e.op; fn_drv = e.fn; mr_drv = e.mr; z_drv = e.z;
            @(negedge clk);
            checks++;
            if (bus.state !== e.st) $display("FAIL %s state got %0d want %0d", e.tag, bus.state, e.st);
            else passed++;
            checks++;
            if (obs_main !== e.outs) $display("FAIL %s outs got %h want %h", e.tag, obs_main, e.outs);
            else passed++;
            @(posedge clk); #1;
        end
        rst_n  = 1'b0;
        mr_drv = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd0 || obs_main !== o_rst()) $display("FAIL rst_midrd state=%0d outs=%h want 0/%h", bus.state, obs_main, o_rst());
        else passed++;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mr_drv = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd0 || obs_main !== o_fetch(0)) $display("FAIL rst_release state=%0d outs=%h want 0/%h", bus.state, obs_main, o_fetch(0));
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_sw();
        exp_t e;
        push(6'b100011, 6'd0, 1, 0, 4'd0, o_fetch(1), "lw.fetch");
        push(6'b100011, 6'd0, 1, 0, 4'd1, o_dec(),    "lw.decode");
        push(6'b100011, 6'd0, 1, 0, 4'd2, o_maddr(),  "lw.maddr");
        push(6'b100011, 6'd0, 1, 0, 4'd3, o_mrd(),    "lw.memrd");
        push(6'b100011, 6'd0, 1, 0, 4'd4, o_mwb(),    "lw.memwb");
        push(6'b101011, 6'd0, 1, 0, 4'd0, o_fetch(1), "sw.fetch");
        push(6'b101011, 6'd0, 1, 0, 4'd1, o_dec(),    "sw.decode");
        push(6'b101011, 6'd0, 1, 0, 4'd2, o_maddr(),  "sw.maddr");
        for (int i = 0; i < 3; i++)
            push(6'b101011, 6'd0, 0, 0, 4'd5, o_mwr(), "sw.memwr_wait");
        push(6'b101011, 6'd0, 1, 0, 4'd5, o_mwr(),    "sw.memwr_done");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op_drv = e.op; fn_drv = e.fn; mr_drv = e.mr; z_drv = e.z;
            @(negedge clk);
            checks++;
            if (bus.state !== e.st) $display("FAIL %s state got %0d want %0d", e.tag, bus.state, e.st);
            else passed++;
            checks++;
            if (obs_main !== e.outs) $display("FAIL %s outs got %h want %h", e.tag, obs_main, e.outs);
            else passed++;
            checks++;
            if ({bus.illegal, bus.memTimeout} !== e.flg) $display("FAIL %s flags got %b want %b", e.tag, {bus.illegal, bus.memTimeout}, e.flg);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        exp_t e;
        push(6'b000100, 6'd0, 1, 0, 4'd0, o_fetch(1), "beq1.fetch");
        push(6'b000100, 6'd0, 1, 0, 4'd1, o_dec(),    "beq1.decode");
        push(6'b000100, 6'd0, 1, 1, 4'd8, o_br(1),    "beq1.branch");
        push(6'b000100, 6'd0, 1, 0, 4'd0, o_fetch(1), "beq0.fetch");
        push(6'b000100, 6'd0, 1, 0, 4'd1, o_dec(),    "beq0.decode");
        push(6'b000100, 6'd0, 1, 0, 4'd8, o_br(0),    "beq0.branch");
        push(6'b000010, 6'd0, 1, 0, 4'd0, o_fetch(1), "j.fetch");
        push(6'b000010, 6'd0, 1, 0, 4'd1, o_dec(),    "j.decode");
        push(6'b000010, 6'd0, 1, 0, 4'd9, o_jmp(),    "j.jump");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op_drv = e.op; fn_drv = e.fn; mr_drv = e.mr; z_drv = e.z;
            @(negedge clk);
            checks++;
            if (bus.state !== e.st) $display("FAIL %s state got %0d want %0d", e.tag, bus.state, e.st);
            else passed++;
            checks++;
            if (obs_main !== e.outs) $display("FAIL %s outs got %h want %h", e.tag, obs_main, e.outs);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imm();
        exp_t e;
        push(6'b001101, 6'd0, 1, 0, 4'd0, o_fetch(1), "ori.fetch");
        push(6'b001101, 6'd0, 1, 0, 4'd1, o_dec(),    "ori.decode");
`ifdef IMM_ALU_EN
        push(6'b001101, 6'd0, 1, 0, 4'd10, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0001), "ori.iexec");
        push(6'b001101, 6'd0, 1, 0, 4'd11, mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,4'b0010), "ori.iwb");
`else
        exp_ill = 1'b1;
`endif
        push(6'b001101, 6'd0, 0, 0, 4'd0, o_fetch(0), "ori.after");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op_drv = e.op; fn_drv = e.fn; mr_drv = e.mr; z_drv = e.z;
            @(negedge clk);
            checks++;
            if (bus.state !== e.st) $display("FAIL %s state got %0d want %0d", e.tag, bus.state, e.st);
            else passed++;
            checks++;
            if (obs_main !== e.outs) $display("FAIL %s outs got %h want %h", e.tag, obs_main, e.outs);
            else passed++;
            checks++;
            if ({bus.illegal, bus.memTimeout} !== e.flg) $display("FAIL %s flags got %b want %b", e.tag, {bus.illegal, bus.memTimeout}, e.flg);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        exp_t e;
        push(6'b000000, 6'b101010, 1, 0, 4'd0, o_fetch(1),        "slt.fetch");
        push(6'b000000, 6'b101010, 1, 0, 4'd1, o_dec(),           "slt.decode");
        push(6'b000000, 6'b101010, 1, 0, 4'd6, o_rexec(4'b0111),  "slt.rexec");
        push(6'b000000, 6'b101010, 1, 0, 4'd7, o_rwb(4'b0111),    "slt.rwb");
        push(6'b000000, 6'b100010, 1, 0, 4'd0, o_fetch(1),        "sub.fetch");
        push(6'b000000, 6'b100010, 1, 0, 4'd1, o_dec(),           "sub.decode");
        push(6'b000000, 6'b100010, 1, 0, 4'd6, o_rexec(4'b0110),  "sub.rexec");
        push(6'b000000, 6'b100010, 1, 0, 4'd7, o_rwb(4'b0110),    "sub.rwb");
        push(6'b000000, 6'b111111, 1, 0, 4'd0, o_fetch(1),        "bad.fetch");
        push(6'b000000, 6'b111111, 1, 0, 4'd1, o_dec(),           "bad.decode");
        push(6'b000000, 6'b111111, 1, 0, 4'd6, o_rexec(4'b0010),  "bad.rexec");
        exp_ill = 1'b1;
        push(6'b000000, 6'b111111, 0, 0, 4'd0, o_fetch(0),        "bad.after");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op_drv = e.op; fn_drv = e.fn; mr_drv = e.mr; z_drv = e.z;
            @(negedge clk);
            checks++;
            if (bus.state !== e.st) $display("FAIL %s state got %0d want %0d", e.tag, bus.state, e.st);
            else passed++;
            checks++;
            if (obs_main !== e.outs) $display("FAIL %s outs got %h want %h", e.tag, obs_main, e.outs);
            else passed++;
            checks++;
            if ({bus.illegal, bus.memTimeout} !== e.flg) $display("FAIL %s flags got %b want %b", e.tag, {bus.illegal, bus.memTimeout}, e.flg);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        rst_n  = 1'b0;
        mr_drv = 1'b0;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_to.illegal, bus_to.memTimeout} !== 2'b00) $display("FAIL to.reset flags got %b want 00", {bus_to.illegal, bus_to.memTimeout});
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(6'b101011, 6'd0, 1, 0, 4'd0, o_fetch(1), "to.sw.fetch");
        push(6'b101011, 6'd0, 1, 0, 4'd1, o_dec(),    "to.sw.decode");
        push(6'b101011, 6'd0, 1, 0, 4'd2, o_maddr(),  "to.sw.maddr");
        push(6'b101011, 6'd0, 0, 0, 4'd5, o_mwr(),    "to.sw.wait1");
        push(6'b101011, 6'd0, 0, 0, 4'd5, o_mwr(),    "to.sw.wait2");
        exp_to = 1'b1;
        push(6'b100011, 6'd0, 1, 0, 4'd0, o_fetch(1), "to.lw.fetch");
        push(6'b100011, 6'd0, 1, 0, 4'd1, o_dec(),    "to.lw.decode");
        push(6'b100011, 6'd0, 1, 0, 4'd2, o_maddr(),  "to.lw.maddr");
        push(6'b100011, 6'd0, 0, 0, 4'd3, o_mrd(),    "to.lw.wait1");
        push(6'b100011, 6'd0, 0, 0, 4'd3, o_mrd(),    "to.lw.wait2");
        for (int i = 0; i < 3; i++)
            push(6'b000010, 6'd0, 0, 0, 4'd0, o_fetch(0), "to.fetch.stall");
        push(6'b000010, 6'd0, 1, 0, 4'd0, o_fetch(1), "to.j.fetch");
        push(6'b000010, 6'd0, 1, 0, 4'd1, o_dec(),    "to.j.decode");
        push(6'b000010, 6'd0, 1, 0, 4'd9, o_jmp(),    "to.j.jump");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op_drv = e.op; fn_drv = e.fn; mr_drv = e.mr; z_drv = e.z;
            @(negedge clk);
            checks++;
            if (bus_to.state !== e.st) $display("FAIL %s state got %0d want %0d", e.tag, bus_to.state, e.st);
            else passed++;
            checks++;
            if (obs_to !== e.outs) $display("FAIL %s outs got %h want %h", e.tag, obs_to, e.outs);
            else passed++;
            checks++;
            if ({bus_to.illegal, bus_to.memTimeout} !== e.flg) $display("FAIL %s flags got %b want %b", e.tag, {bus_to.illegal, bus_to.memTimeout}, e.flg);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        op_drv = 6'd0;
        fn_drv = 6'd0;
        mr_drv = 1'b0;
        z_drv  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lw_sw();
        test_branch_jump();
        test_imm();
        test_rtype();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control FSM for the MIPS datapath.
- Issues operations to the ALU: drives aluCtr (4-bit ALU encoding) and the operand selects, and consumes the ALU zero flag.
- Sequences fetch, decode, execute, memory and writeback with a ready handshake to the memory.
- Sits between the instruction register (opcode/funct) and the datapath muxes/enables.

Parameters:
MEM_TIMEOUT, 255, memory-wait cycles before abandoning an access; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
memReady  input  1  memory handshake: access completes in a cycle with memReady=1
pcWrite  output  1  PC load enable
iorD  output  1  memory address select: 0 PC, 1 aluOut
memRead  output  1  memory read request
memWrite  output  1  memory write request
irWrite  output  1  IR load enable
memToReg  output  1  register write data: 0 aluOut, 1 MDR
regDst  output  1  destination register: 0 rt, 1 rd
regWrite  output  1  register file write enable
aluSrcA  output  1  ALU A: 0 PC, 1 regA
aluSrcB  output  2  ALU B: 00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
pcSource  output  2  PC source: 00 ALU result, 01 aluOut, 10 jump target
aluCtr  output  4  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
state  output  4  current state (debug)
illegal  output  1  sticky: unsupported opcode or funct seen
memTimeout  output  1  sticky: memory wait exceeded MEM_TIMEOUT

Behaviour:
Reset:
- Async on rst_n=0: state=FETCH(0); illegal=0; memTimeout=0; wait counter=0.
- While rst_n=0, all strobes and selects are forced 0 and aluCtr=0010.

Output rule:
- Outputs are combinational from state (plus memReady/zero where stated).
- Unlisted outputs are 0; aluCtr defaults to 0010.

States and transitions:
- FETCH(0): memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluCtr=0010, pcSource=00.
  - irWrite=pcWrite=memReady.
  - memReady=1 -> DECODE; otherwise stay.
- DECODE(1): aluSrcA=0, aluSrcB=11, aluCtr=0010 (branch target into aluOut). Next state by opcode:
  - 100011 lw / 101011 sw -> MEM_ADDR
  - 000000 -> R_EXEC
  - 000100 beq -> BRANCH
  - 000010 j -> JUMP
  - any other opcode -> set illegal, go to FETCH.
- MEM_ADDR(2): aluSrcA=1, aluSrcB=10, aluCtr=0010 -> MEM_RD if lw, MEM_WR if sw.
- MEM_RD(3): memRead=1, iorD=1; memReady=1 -> MEM_WB.
- MEM_WB(4): regWrite=1, memToReg=1, regDst=0 -> FETCH.
- MEM_WR(5): memWrite=1, iorD=1; memReady=1 -> FETCH.
- R_EXEC(6): aluSrcA=1, aluSrcB=00; aluCtr decoded from funct:
  - 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111.
  - Unknown funct -> set illegal, go to FETCH with no writeback.
  - Known funct -> R_WB.
- R_WB(7): regWrite=1, regDst=1, memToReg=0; aluCtr holds the funct decode -> FETCH.
- BRANCH(8): aluSrcA=1, aluSrcB=00, aluCtr=0110, pcSource=01, pcWrite=zero (same cycle) -> FETCH.
- JUMP(9): pcWrite=1, pcSource=10 -> FETCH.

Memory wait:
- In FETCH, MEM_RD and MEM_WR, the counter increments each cycle memReady=0.
- It clears on any state change or on memReady=1.
- When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT:
  - memTimeout is set.
  - FETCH stays in FETCH with the counter cleared.
  - MEM_RD/MEM_WR abandon the access and go to FETCH; no regWrite occurs.

Latency with memReady held 1:
- lw 5 cycles; sw 4; R-type 4; beq 3; j 3.

Sticky flags:
- illegal and memTimeout clear only on reset.
- An illegal instruction never asserts regWrite, memWrite or pcWrite beyond its FETCH.

Optional Feature:
IMM_ALU_EN.
- Defined: DECODE also accepts 001000 addi, 001100 andi, 001101 ori, 001010 slti -> I_EXEC(10).
  - I_EXEC: aluSrcA=1, aluSrcB=10; aluCtr 0010/0000/0001/0111 respectively -> I_WB(11).
  - I_WB: regWrite=1, regDst=0, memToReg=0 -> FETCH.
  - Latency 4 cycles. Immediates are sign-extended by the datapath for all four, including andi/ori.
- Undefined: these opcodes are illegal; states 10/11 do not exist.

Test Plan:
- Reset mid-MEM_RD (rst_n low 1 cycle) -> state=0, all strobes 0 during reset, FETCH outputs with memRead=1 on release.
- lw (opcode 100011), memReady=1 -> states 0,1,2,3,4,0; regWrite=1 and memToReg=1 only in cycle 5.
- R-type funct 101010 -> aluCtr=0111 in R_EXEC and R_WB; regDst=1 in R_WB. Then funct 111111 -> illegal=1, no regWrite.
- beq with zero=1 -> pcWrite=1, pcSource=01, aluCtr=0110 in state 8; repeat with zero=0 -> pcWrite=0.
- sw with memReady low 3 cycles in MEM_WR -> memWrite=1 held 4 cycles, then FETCH. With MEM_TIMEOUT=2 -> memTimeout=1, FETCH after 2 wait cycles.
- IMM_ALU_EN defined, ori 001101 -> states 0,1,10,11,0; aluCtr=0001, aluSrcB=10. Undefined -> illegal=1.
